usb1d_tx_pa: RTL

USB1.1 device-side packet assembler, the transmit-side counterpart of the packet disassembler.
- Sends handshake packets (ACK/NAK/STALL/NYET) and data packets (DATA0/1/2/MDATA, payload plus CRC16) on the UTMI TX byte interface.
- Sits between the protocol engine / endpoint memory and the UTMI PHY.

---
 rtl/usb1d_pkg.sv | 38 +++
 rtl/usb1d_crc16.sv | 24 ++
 rtl/usb1d_tx_pa.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb1d_pkg.sv
// Shared USB1.1 device definitions: PID codes, TX assembler states and CRC16 constants.
// Used by the packet assembler and the CRC16 byte-update helper.
package usb1d_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_GAP
  } tx_state_e;

  // On-wire PID byte carries the check nibble in the upper half.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/usb1d_crc16.sv
// Combinational USB CRC16 update over one byte, bits consumed LSB-first.
// Zero latency; no flow control.
module usb1d_crc16
  import usb1d_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;
  logic        fb;

  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb = c[15] ^ data_i[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb1d_tx_pa.sv
// USB1.1 device TX packet assembler: handshake and data packets onto the UTMI byte interface.
// PID appears the cycle after the request; bytes advance only on tx_valid & tx_ready and hold otherwise.
module usb1d_tx_pa
  import usb1d_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int TX_GAP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_token,
  input  logic [1:0] token_pid_sel,
  input  logic       send_data,
  input  logic [1:0] data_pid_sel,
  input  logic       send_zero_length,
  input  logic [7:0] src_data,
  input  logic       src_avail,
  input  logic       src_last,
  output logic       rd_next,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_first,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       underrun_err,
  output logic       len_err
);

  localparam logic [9:0] MAX_CNT  = 10'(MAX_PAYLOAD);
  localparam logic [3:0] GAP_LAST = (TX_GAP == 0) ? 4'd0 : 4'(TX_GAP - 1);
  localparam tx_state_e  POST_PKT = (TX_GAP == 0) ? S_IDLE : S_GAP;

  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic        busy_q, busy_d, done_q, done_d, under_q, under_d, len_q, len_d;
  logic [15:0] crc_q, crc_d, crc_upd, crc_tx;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        src_last_q, src_last_d, is_data_q, is_data_d, zlen_q, zlen_d;
  logic        accept, pkt_end, pop;
  logic [3:0]  tok_pid, dat_pid;

  usb1d_crc16 u_crc16 (
    .crc_i  (crc_q),
    .data_i (src_data),
    .crc_o  (crc_upd)
  );

  always_comb begin
    unique case (token_pid_sel)
      2'd0:    tok_pid = PID_ACK;
      2'd1:    tok_pid = PID_NAK;
      2'd2:    tok_pid = PID_STALL;
      default: tok_pid = PID_NYET;
    endcase
    unique case (data_pid_sel)
      2'd0:    dat_pid = PID_DATA0;
      2'd1:    dat_pid = PID_DATA1;
      2'd2:    dat_pid = PID_DATA2;
      default: dat_pid = PID_MDATA;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    valid_d    = valid_q;
    first_d    = first_q;
    last_d     = last_q;
    done_d     = 1'b0;
    under_d    = 1'b0;
    len_d      = 1'b0;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    src_last_d = src_last_q;
    is_data_d  = is_data_q;
    zlen_d     = zlen_q;
    rd_next    = 1'b0;
    pop        = 1'b0;
    accept     = valid_q & tx_ready;
    pkt_end    = src_last_q | (cnt_q == MAX_CNT);
    crc_tx     = ~bitrev16(crc_q);

    unique case (state_q)
      S_IDLE: begin
        if (send_token) begin
          tx_data_d = pid_byte(tok_pid);
          valid_d   = 1'b1;
          first_d   = 1'b1;
          last_d    = 1'b1;
          is_data_d = 1'b0;
          state_d   = S_PID;
        end else if (send_data) begin
          tx_data_d = pid_byte(dat_pid);
          valid_d   = 1'b1;
          first_d   = 1'b1;
          last_d    = 1'b0;
          is_data_d = 1'b1;
          zlen_d    = send_zero_length;
          crc_d     = CRC16_INIT;
          cnt_d     = 10'd0;
          state_d   = S_PID;
        end
      end
      S_PID: begin
        if (accept) begin
          first_d = 1'b0;
          if (!is_data_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = 4'd0;
            state_d = POST_PKT;
          end else if (zlen_q) begin
            tx_data_d = crc_tx[7:0];
            state_d   = S_CRC_LO;
          end else begin
            pop = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (pkt_end) begin
            len_d     = ~src_last_q;
            tx_data_d = crc_tx[7:0];
            state_d   = S_CRC_LO;
          end else begin
            pop = 1'b1;
          end
        end
      end
      S_CRC_LO: begin
        if (accept) begin
          tx_data_d = crc_tx[15:8];
          last_d    = 1'b1;
          state_d   = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          gap_d   = 4'd0;
          state_d = POST_PKT;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Fetch the next payload byte, or abort the packet without CRC if the source ran dry.
    if (pop) begin
      if (src_avail) begin
        rd_next    = 1'b1;
        tx_data_d  = src_data;
        crc_d      = crc_upd;
        cnt_d      = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 10'd1;
        src_last_d = src_last;
        state_d    = S_DATA;
      end else begin
        under_d = 1'b1;
        valid_d = 1'b0;
        gap_d   = 4'd0;
        state_d = POST_PKT;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      under_q    <= 1'b0;
      len_q      <= 1'b0;
      crc_q      <= CRC16_INIT;
      cnt_q      <= 10'd0;
      gap_q      <= 4'd0;
      src_last_q <= 1'b0;
      is_data_q  <= 1'b0;
      zlen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      under_q    <= under_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      src_last_q <= src_last_d;
      is_data_q  <= is_data_d;
      zlen_q     <= zlen_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = valid_q;
  assign tx_first     = first_q;
  assign tx_last      = last_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign underrun_err = under_q;
  assign len_err      = len_q;

endmodule
